// File: rtl/gray_decoder_tracker.sv
// gray_decoder_tracker
//
// Registered Gray-to-binary decoder with position tracking. This is the
// receive end of a binary-to-Gray encoder. Each accepted Gray sample is
// converted to binary and compared with the previous accepted value. The
// transition is classified as hold, +1, -1 or an illegal jump. A signed
// position accumulator, a saturating illegal-jump counter and a sticky
// FAULT state are kept alongside.
//
// Optional feature (macro GRAY_SYNC_EN):
//   Defined     - G and g_valid pass through a 2-flop synchronizer before the
//                 decode stage. Input-to-B latency is 3 cycles.
//   Not defined - no synchronizer. Input-to-B latency is 1 cycle.
//
// Parameters:
//   WIDTH - width of the Gray input and binary output (>= 2)
//   POS_W - width of the signed position accumulator
//   ERR_W - width of the saturating illegal-jump counter
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset (priority over clr/g_valid)
//   g_valid  in   G is sampled this cycle
//   G        in   Gray-coded input word
//   clr      in   synchronous clear of fault, error count and position;
//                 returns the tracker to IDLE
//   B        out  binary value of the last accepted sample
//   b_valid  out  one-cycle pulse: B and the step flags were updated
//   step_up  out  one-cycle pulse: sample = previous + 1 (mod 2^WIDTH)
//   step_dn  out  one-cycle pulse: sample = previous - 1 (mod 2^WIDTH)
//   step_err out  one-cycle pulse: illegal jump
//   fault    out  high while in FAULT
//   pos      out  signed two's-complement position (wraps)
//   err_cnt  out  illegal-jump count, saturating at all-ones

module gray_decoder_tracker #(
    parameter int WIDTH = 4,
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g_valid,
    input  logic [WIDTH-1:0] G,
    input  logic             clr,
    output logic [WIDTH-1:0] B,
    output logic             b_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_err,
    output logic             fault,
    output logic [POS_W-1:0] pos,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input stage: the sample actually seen by the decoder
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] g_smp;
    logic             v_smp;

`ifdef GRAY_SYNC_EN
    logic [WIDTH-1:0] g_s1_q, g_s2_q;
    logic             v_s1_q, v_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            g_s1_q <= '0;
            g_s2_q <= '0;
            v_s1_q <= 1'b0;
            v_s2_q <= 1'b0;
        end else begin
            g_s1_q <= G;
            g_s2_q <= g_s1_q;
            v_s1_q <= g_valid;
            v_s2_q <= v_s1_q;
        end
    end

    assign g_smp = g_s2_q;
    assign v_smp = v_s2_q;
`else
    assign g_smp = G;
    assign v_smp = g_valid;
`endif

    // ------------------------------------------------------------------
    // Gray-to-binary conversion. Binary bit i is the XOR of Gray bits
    // i..WIDTH-1. A shifted reduction keeps each bit independent of the
    // others, so there is no ripple chain through one vector.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bin_d;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bin
            assign bin_d[gi] = ^(g_smp >> gi);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode / classify / track
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] b_q;
    logic             b_valid_q;
    logic             step_up_q;
    logic             step_dn_q;
    logic             step_err_q;
    logic             fault_q;
    logic [POS_W-1:0] pos_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic [WIDTH-1:0] delta_d;
    assign delta_d = bin_d - prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            b_q        <= '0;
            b_valid_q  <= 1'b0;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            step_err_q <= 1'b0;
            fault_q    <= 1'b0;
            pos_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            // Pulses default low; they are only raised for an accepted sample.
            b_valid_q  <= 1'b0;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            step_err_q <= 1'b0;

            if (clr) begin
                // A same-cycle sample is dropped; B and prev are kept.
                state_q   <= ST_IDLE;
                fault_q   <= 1'b0;
                pos_q     <= '0;
                err_cnt_q <= '0;
            end else if (v_smp) begin
                b_q       <= bin_d;
                prev_q    <= bin_d;
                b_valid_q <= 1'b1;

                case (state_q)
                    ST_IDLE: begin
                        // The first sample only establishes the reference.
                        state_q <= ST_TRACK;
                    end
                    default: begin
                        // TRACK and FAULT classify the same way. FAULT is
                        // sticky and is left only by clr or rst.
                        if (delta_d == '0) begin
                            // hold
                        end else if (delta_d == WIDTH'(1)) begin
                            step_up_q <= 1'b1;
                            pos_q     <= pos_q + POS_W'(1);
                        end else if (delta_d == {WIDTH{1'b1}}) begin
                            step_dn_q <= 1'b1;
                            pos_q     <= pos_q - POS_W'(1);
                        end else begin
                            step_err_q <= 1'b1;
                            fault_q    <= 1'b1;
                            state_q    <= ST_FAULT;
                            if (err_cnt_q != {ERR_W{1'b1}}) begin
                                err_cnt_q <= err_cnt_q + ERR_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign B        = b_q;
    assign b_valid  = b_valid_q;
    assign step_up  = step_up_q;
    assign step_dn  = step_dn_q;
    assign step_err = step_err_q;
    assign fault    = fault_q;
    assign pos      = pos_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_decoder_tracker.sv
// Directed testbench for gray_decoder_tracker (default build, 1-cycle
// latency). Expected values are hand-computed constants.

module tb_gray_decoder_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       g_valid;
    logic [3:0] G;
    logic       clr;
    logic [3:0] B;
    logic       b_valid;
    logic       step_up;
    logic       step_dn;
    logic       step_err;
    logic       fault;
    logic [7:0] pos;
    logic [3:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    gray_decoder_tracker #(.WIDTH(4), .POS_W(8), .ERR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .g_valid  (g_valid),
        .G        (G),
        .clr      (clr),
        .B        (B),
        .b_valid  (b_valid),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .step_err (step_err),
        .fault    (fault),
        .pos      (pos),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, sample 1 time unit later.
    task automatic apply(input logic [3:0] g, input logic v, input logic c);
        G       = g;
        g_valid = v;
        clr     = c;
        @(posedge clk);
        #1;
        g_valid = 1'b0;
        clr     = 1'b0;
        $display("G=%b v=%0d clr=%0d -> B=%0d bv=%0d up=%0d dn=%0d err=%0d fault=%0d pos=%0d ecnt=%0d",
                 g, v, c, B, b_valid, step_up, step_dn, step_err, fault, pos, err_cnt);
    endtask

    // Check the full output set after a step.
    task automatic chk_all(input string tag, input logic [3:0] eb, input logic ev,
                           input logic eu, input logic ed, input logic ee,
                           input logic ef, input logic [7:0] ep, input logic [3:0] ec);
        chk({tag, ".B"},        32'(B),        32'(eb));
        chk({tag, ".b_valid"},  32'(b_valid),  32'(ev));
        chk({tag, ".step_up"},  32'(step_up),  32'(eu));
        chk({tag, ".step_dn"},  32'(step_dn),  32'(ed));
        chk({tag, ".step_err"}, 32'(step_err), 32'(ee));
        chk({tag, ".fault"},    32'(fault),    32'(ef));
        chk({tag, ".pos"},      32'(pos),      32'(ep));
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(ec));
    endtask

    initial begin
        rst = 1'b1; g_valid = 1'b0; G = 4'b0000; clr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_all("reset", 4'd0, 0, 0, 0, 0, 0, 8'd0, 4'd0);
        rst = 1'b0;

        // First sample: no classification
        apply(4'b0000, 1, 0); chk_all("first", 4'd0, 1, 0, 0, 0, 0, 8'd0, 4'd0);

        // Count up 1..4
        apply(4'b0001, 1, 0); chk_all("up1", 4'd1, 1, 1, 0, 0, 0, 8'd1, 4'd0);
        apply(4'b0011, 1, 0); chk_all("up2", 4'd2, 1, 1, 0, 0, 0, 8'd2, 4'd0);
        apply(4'b0010, 1, 0); chk_all("up3", 4'd3, 1, 1, 0, 0, 0, 8'd3, 4'd0);
        apply(4'b0110, 1, 0); chk_all("up4", 4'd4, 1, 1, 0, 0, 0, 8'd4, 4'd0);

        // No valid: hold, no pulses (G changes but must be ignored)
        apply(4'b1111, 0, 0); chk_all("idle", 4'd4, 0, 0, 0, 0, 0, 8'd4, 4'd0);

        // Same value: hold classification
        apply(4'b0110, 1, 0); chk_all("hold", 4'd4, 1, 0, 0, 0, 0, 8'd4, 4'd0);

        // Continue up to 15
        apply(4'b0111, 1, 0); apply(4'b0101, 1, 0); apply(4'b0100, 1, 0);
        apply(4'b1100, 1, 0); apply(4'b1101, 1, 0); apply(4'b1111, 1, 0);
        apply(4'b1110, 1, 0); apply(4'b1010, 1, 0); apply(4'b1011, 1, 0);
        apply(4'b1001, 1, 0);
        apply(4'b1000, 1, 0); chk_all("up15", 4'd15, 1, 1, 0, 0, 0, 8'd15, 4'd0);

        // Wrap-around both directions
        apply(4'b0000, 1, 0); chk_all("wrap_up", 4'd0,  1, 1, 0, 0, 0, 8'd16, 4'd0);
        apply(4'b1000, 1, 0); chk_all("wrap_dn", 4'd15, 1, 0, 1, 0, 0, 8'd15, 4'd0);
        apply(4'b0000, 1, 0); chk_all("wrap_up2", 4'd0, 1, 1, 0, 0, 0, 8'd16, 4'd0);

        // Illegal jump 0 -> 2
        apply(4'b0011, 1, 0); chk_all("jump", 4'd2, 1, 0, 0, 1, 1, 8'd16, 4'd1);

        // 16 further illegal jumps alternating 8 / 2 -> counter saturates
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) apply(4'b1100, 1, 0);
            else            apply(4'b0011, 1, 0);
        end
        chk_all("sat", 4'd2, 1, 0, 0, 1, 1, 8'd16, 4'd15);

        // FAULT still tracks legal steps
        apply(4'b0010, 1, 0); chk_all("fault_up", 4'd3, 1, 1, 0, 0, 1, 8'd17, 4'd15);

        // clr with same-cycle sample: sample dropped, B held
        apply(4'b0000, 1, 1); chk_all("clr", 4'd3, 0, 0, 0, 0, 0, 8'd0, 4'd0);

        // Next sample is a first sample (3 -> 4 would otherwise be step_up)
        apply(4'b0110, 1, 0); chk_all("post_clr", 4'd4, 1, 0, 0, 0, 0, 8'd0, 4'd0);
        apply(4'b0111, 1, 0); chk_all("post_up", 4'd5, 1, 1, 0, 0, 0, 8'd1, 4'd0);

        // pos wraps below zero
        apply(4'b0110, 1, 0); chk_all("dn0", 4'd4, 1, 0, 1, 0, 0, 8'd0, 4'd0);
        apply(4'b0010, 1, 0); chk_all("dn_wrap", 4'd3, 1, 0, 1, 0, 0, 8'hFF, 4'd0);

        // Get into FAULT again, then rst mid-stream with g_valid high
        apply(4'b1100, 1, 0); chk_all("jump2", 4'd8, 1, 0, 0, 1, 1, 8'hFF, 4'd1);
        rst = 1'b1;
        apply(4'b0111, 1, 0); chk_all("rst_mid", 4'd0, 0, 0, 0, 0, 0, 8'd0, 4'd0);
        rst = 1'b0;

        // After reset, 0 -> 6 would be illegal; as a first sample it is not
        apply(4'b0101, 1, 0); chk_all("post_rst", 4'd6, 1, 0, 0, 0, 0, 8'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
